timer_counter: RTL

//   Memory-mapped down-counting timer. Two instances (TC0 at 0x7F00..0x7F0B, TC1 at 0x7F10..0x7F1B)
//   sit directly downstream of the system bridge and consume its per-timer addr/we/wdata strobes.

---
 rtl/timer_counter_if.sv | 17 +
 rtl/timer_counter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/timer_counter_if.sv
// Bus bundle between the system bridge and one timer_counter instance.
//   addr   byte address from the bridge (only addr[3:2] is decoded by the timer)
//   we     word write strobe
//   wdata  store data
//   rdata  combinational read data for the addressed word
//   irq    interrupt request towards CP0
// master: bridge side. slave: timer side.
interface timer_counter_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer.
// Word map (addr[3:2]):
//   0 CTRL   R/W  [3] IM irq mask, [2:1] MODE (01 = auto-reload), [0] EN
//   1 PRESET R/W  reload value
//   2 COUNT  RO   current count
//   3 -      reads 0, writes ignored
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high
//   bus    timer_counter_if slave: addr/we/wdata in, rdata/irq out
// irq = irq_flag & IM. A one-shot expiry leaves irq_flag set until the CPU
// writes CTRL or PRESET; in auto-reload the flag is high for one cycle per period.
module timer_counter (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'b01;

  state_t      state, state_nxt;
  logic [3:0]  ctrl, ctrl_nxt;
  logic [31:0] preset, preset_nxt;
  logic [31:0] count, count_nxt;
  logic        irq_flag, irq_flag_nxt;

  logic [1:0]  offset;
  logic        en;
  logic [1:0]  mode;
  logic        flag_set;
  logic        flag_clr;

  // Address bits outside the word offset are decoded by the bridge.
  logic        unused_addr;
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

  assign offset = bus.addr[3:2];
  assign en     = ctrl[0];
  assign mode   = ctrl[2:1];

  // Next-state and register-update logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // can leave one unassigned and infer a latch.
    state_nxt    = state;
    ctrl_nxt     = ctrl;
    preset_nxt   = preset;
    count_nxt    = count;
    irq_flag_nxt = irq_flag;
    flag_set     = 1'b0;
    flag_clr     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // COUNT of 1 or 0 expires; PRESET=0 lands here after one CNT cycle.
          count_nxt = 32'd0;
          flag_set  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (mode == MODE_AUTO) begin
          flag_clr  = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          ctrl_nxt[0] = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // CPU writes are applied after the FSM so a CTRL store overrides the
    // FSM clearing EN in the same cycle.
    if (bus.we) begin
      unique case (offset)
        OFF_CTRL: begin
          ctrl_nxt = bus.wdata[3:0];
          flag_clr = 1'b1;
        end
        OFF_PRESET: begin
          preset_nxt = bus.wdata;
          flag_clr   = 1'b1;
        end
        default: ;
      endcase
    end

    // Setting beats clearing when both happen on the same edge.
    if (flag_set)      irq_flag_nxt = 1'b1;
    else if (flag_clr) irq_flag_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from
    // pre-edge values regardless of statement order.
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      irq_flag <= irq_flag_nxt;
    end
  end

  // Read data reflects the registers as they stand; a write in the same
  // cycle becomes visible only after the edge.
  always_comb begin
    unique case (offset)
      OFF_CTRL:   bus.rdata = {28'd0, ctrl};
      OFF_PRESET: bus.rdata = preset;
      OFF_COUNT:  bus.rdata = count;
      default:    bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = irq_flag & ctrl[3];

endmodule
